// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the twiddle-factor generator used to
// elaborate the per-lane twiddle ROMs.
package fft_pkg;

  localparam int N        = 512;
  localparam int DEPTH    = 16;
  localparam int TW_WIDTH = 9;
  localparam int TW_FRAC  = 7;
  localparam int BLOCKS   = N / DEPTH;

  typedef struct packed {
    logic signed [TW_WIDTH-1:0] c;
    logic signed [TW_WIDTH-1:0] s;
  } tw_t;

  // W_N^e = c - j*s, both rounded to TW_FRAC fractional bits; elaboration-time only.
  function automatic tw_t twiddle(input int e);
    real  ang;
    tw_t  w;
    ang = 2.0 * 3.14159265358979323846 * real'(e) / real'(N);
    w.c = TW_WIDTH'(int'(real'(2 ** TW_FRAC) * $cos(ang)));
    w.s = TW_WIDTH'(int'(real'(2 ** TW_FRAC) * $sin(ang)));
    return w;
  endfunction

endpackage

// File: rtl/twiddle_mul_stage_if.sv
// Bundle-in / bundle-out signals between the butterfly stage, the twiddle
// multiplier and the next butterfly.
interface twiddle_mul_stage_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
);
  logic                        valid_in;
  logic                        sof_in;
  logic [DEPTH-1:0][WIDTH-1:0] din_R;
  logic [DEPTH-1:0][WIDTH-1:0] din_Q;
  logic                        valid_out;
  logic                        sof_out;
  logic                        eof_out;
  logic [DEPTH-1:0][WIDTH:0]   dout_R;
  logic [DEPTH-1:0][WIDTH:0]   dout_Q;

  modport master (
    output valid_in, sof_in, din_R, din_Q,
    input  valid_out, sof_out, eof_out, dout_R, dout_Q
  );

  modport slave (
    input  valid_in, sof_in, din_R, din_Q,
    output valid_out, sof_out, eof_out, dout_R, dout_Q
  );
endinterface

// File: rtl/twiddle_cmul.sv
// Single-lane complex multiply by a conjugate-form twiddle (c - j*s):
// products registered in S2, sum + round-half-up in S3.
module twiddle_cmul
  import fft_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_s2,
  input  logic             en_s3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  tw_t              tw,
  output logic [WIDTH:0]   re,
  output logic [WIDTH:0]   im
);
  localparam int PW = WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(2 ** (TW_FRAC - 1));

  logic signed [PW-1:0] a_x, q_x, c_x, s_x;
  logic signed [PW-1:0] ac, qs, qc, as_p;
  logic signed [SW-1:0] re_sum, im_sum;

  assign a_x = PW'($signed(a));
  assign q_x = PW'($signed(q));
  assign c_x = PW'(tw.c);
  assign s_x = PW'(tw.s);

  always_ff @(posedge clk) begin
    if (en_s2) begin
      ac   <= a_x * c_x;
      qs   <= q_x * s_x;
      qc   <= q_x * c_x;
      as_p <= a_x * s_x;
    end
  end

  assign re_sum = SW'(ac) + SW'(qs) + RND;
  assign im_sum = SW'(qc) - SW'(as_p) + RND;

  // |W| <= 1 keeps the result inside WIDTH+1 bits, so plain truncation is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      re <= '0;
      im <= '0;
    end else if (en_s3) begin
      re <= (WIDTH+1)'(re_sum >>> TW_FRAC);
      im <= (WIDTH+1)'(im_sum >>> TW_FRAC);
    end
  end

endmodule

// File: rtl/twiddle_mul_stage.sv
// Per-lane twiddle rotation of a DEPTH-lane bundle, 3-cycle fixed latency.
// Owns the block counter, ROM lookup (S1) and the sideband pipeline.
module twiddle_mul_stage
  import fft_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int OFFSET = 2
) (
  input  logic               clk,
  input  logic               rst,
  twiddle_mul_stage_if.slave io
);
  localparam int LAT = 3;
  localparam int BW  = $clog2(BLOCKS);

  logic [BW-1:0]  blk, blk_use;
  logic           last_blk;
  logic [LAT-1:0] vld_pipe, sof_pipe, eof_pipe;

  // sof forces block 0 on its own beat, regardless of where the counter sits.
  assign blk_use  = io.sof_in ? '0 : blk;
  assign last_blk = (blk_use == BW'(BLOCKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      blk      <= '0;
      vld_pipe <= '0;
      sof_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], io.valid_in};
      sof_pipe <= {sof_pipe[LAT-2:0], io.valid_in & io.sof_in};
      eof_pipe <= {eof_pipe[LAT-2:0], io.valid_in & last_blk};
      if (io.valid_in) blk <= last_blk ? '0 : blk_use + 1'b1;
    end
  end

  assign io.valid_out = vld_pipe[LAT-1];
  assign io.sof_out   = sof_pipe[LAT-1];
  assign io.eof_out   = eof_pipe[LAT-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_lane
    tw_t              rom [BLOCKS];
    logic [WIDTH-1:0] a_s1, q_s1;
    tw_t              tw_s1;

    // Lane group is fixed per lane, so each ROM only needs one entry per block.
    for (genvar bb = 0; bb < BLOCKS; bb++) begin : g_rom
      localparam tw_t W = twiddle(((k / OFFSET) * bb) % N);
      assign rom[bb] = W;
    end

    always_ff @(posedge clk) begin
      if (io.valid_in) begin
        a_s1  <= io.din_R[k];
        q_s1  <= io.din_Q[k];
        tw_s1 <= rom[blk_use];
      end
    end

    twiddle_cmul #(.WIDTH(WIDTH)) u_cmul (
      .clk   (clk),
      .rst   (rst),
      .en_s2 (vld_pipe[0]),
      .en_s3 (vld_pipe[1]),
      .a     (a_s1),
      .q     (q_s1),
      .tw    (tw_s1),
      .re    (io.dout_R[k]),
      .im    (io.dout_Q[k])
    );
  end

endmodule

// File: tb/tb_twiddle_mul_stage.sv
// Directed + reference-model bench for twiddle_mul_stage.
`timescale 1ns/1ps
module tb_twiddle_mul_stage;
  import fft_pkg::*;

  localparam int  W  = 10;
  localparam int  W1 = W + 1;
  localparam real PI = 3.14159265358979323846;

  typedef logic [DEPTH-1:0][W-1:0]  din_t;
  typedef logic [DEPTH-1:0][W1-1:0] lanes_t;
  typedef struct packed {
    logic   v;
    logic   sof;
    logic   eof;
    lanes_t r;
    lanes_t q;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twiddle_mul_stage_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();
  twiddle_mul_stage #(.WIDTH(W), .OFFSET(2)) dut (.clk(clk), .rst(rst), .io(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W1-1:0] pr(input int r, input int q);
    return {W1'(r), W1'(q)};
  endfunction

  function automatic int tw_c(input int e);
    return int'(128.0 * $cos(2.0 * PI * real'(e) / 512.0));
  endfunction

  function automatic int tw_s(input int e);
    return int'(128.0 * $sin(2.0 * PI * real'(e) / 512.0));
  endfunction

  // Reference model: predicts every output cycle and records valid beats.
  exp_t   pipe [3];
  lanes_t hold_r, hold_q;
  int     mb;
  lanes_t rec_r [256];
  lanes_t rec_q [256];
  logic   rec_eof [256];
  int     n_out = 0;

  always @(posedge clk) begin
    exp_t nx;
    int   bu, e, c, s, a, q, re, im;
    nx = '0;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      hold_r = '0;
      hold_q = '0;
      mb     = 0;
    end else begin
      if (bus.valid_in) begin
        bu     = bus.sof_in ? 0 : mb;
        nx.v   = 1'b1;
        nx.sof = bus.sof_in;
        nx.eof = (bu == BLOCKS - 1);
        for (int k = 0; k < DEPTH; k++) begin
          e  = ((k / 2) * bu) % 512;
          c  = tw_c(e);
          s  = tw_s(e);
          a  = $signed(bus.din_R[k]);
          q  = $signed(bus.din_Q[k]);
          re = (a * c + q * s + 64) >>> 7;
          im = (q * c - a * s + 64) >>> 7;
          nx.r[k] = W1'(re);
          nx.q[k] = W1'(im);
        end
        mb = (bu == BLOCKS - 1) ? 0 : bu + 1;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nx;
      if (pipe[2].v) begin
        hold_r = pipe[2].r;
        hold_q = pipe[2].q;
      end
    end
    #1;
    chk("m_vld", bus.valid_out, pipe[2].v);
    chk("m_sof", bus.sof_out, pipe[2].sof);
    chk("m_eof", bus.eof_out, pipe[2].eof);
    chk("m_R", bus.dout_R, hold_r);
    chk("m_Q", bus.dout_Q, hold_q);
    if (bus.valid_out && n_out < 256) begin
      rec_r[n_out]   = bus.dout_R;
      rec_q[n_out]   = bus.dout_Q;
      rec_eof[n_out] = bus.eof_out;
      n_out++;
    end
  end

  task automatic drive(input logic v, input logic sof, input din_t r, input din_t q);
    bus.valid_in = v;
    bus.sof_in   = sof;
    bus.din_R    = r;
    bus.din_Q    = q;
    @(negedge clk);
  endtask

  initial begin
    din_t       c100, zero, rr, rq;
    lanes_t     all100, all0;
    logic [5:0] pat;
    int         base, neof;

    for (int k = 0; k < DEPTH; k++) begin
      c100[k]   = W'(100);
      all100[k] = W1'(100);
    end
    zero = '0;
    all0 = '0;
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    bus.din_R    = '0;
    bus.din_Q    = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_vld", bus.valid_out, 1'b0);
    chk("rst_sof", bus.sof_out, 1'b0);
    chk("rst_eof", bus.eof_out, 1'b0);
    chk("rst_R", bus.dout_R, all0);
    chk("rst_Q", bus.dout_Q, all0);

    // Frame of 33 identical beats: latency, rotation values, eof, wrap.
    base = n_out;
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, i == 0, c100, zero);
      if (i < 3) chk("lat", bus.valid_out, i == 2);
    end
    repeat (3) drive(1'b0, 1'b0, zero, zero);
    chk("f1_cnt", n_out - base, 33);
    chk("b0_R", rec_r[base], all100);
    chk("b0_Q", rec_q[base], all0);
    chk("b1_l2", {rec_r[base+1][2], rec_q[base+1][2]}, pr(100, -2));
    chk("b16_l0", {rec_r[base+16][0], rec_q[base+16][0]}, pr(100, 0));
    chk("b16_l2", {rec_r[base+16][2], rec_q[base+16][2]}, pr(98, -20));
    chk("b16_l4", {rec_r[base+16][4], rec_q[base+16][4]}, pr(92, -38));
    chk("b16_l15", {rec_r[base+16][15], rec_q[base+16][15]}, pr(20, -98));
    neof = 0;
    for (int i = 0; i < 31; i++) neof += int'(rec_eof[base+i]);
    chk("eof_early", neof, 0);
    chk("eof_last", rec_eof[base+31], 1'b1);
    chk("wrap_eof", rec_eof[base+32], 1'b0);
    chk("wrap_R", rec_r[base+32], all100);
    chk("wrap_Q", rec_q[base+32], all0);

    // Bubbles 1,0,0,1 continue from b=1; counter must not move on bubbles.
    base = n_out;
    pat  = 6'b001001;
    for (int i = 0; i < 6; i++) begin
      drive(pat[i], 1'b0, c100, zero);
      if (i >= 2) chk("bubble", bus.valid_out, pat[i-2]);
    end
    chk("bub_cnt", n_out - base, 2);
    chk("bub_b1", {rec_r[base][15], rec_q[base][15]}, pr(100, -9));
    chk("bub_b2", {rec_r[base+1][15], rec_q[base+1][15]}, pr(98, -17));

    // Reset with two beats in flight.
    drive(1'b1, 1'b0, c100, zero);
    drive(1'b1, 1'b0, c100, zero);
    rst = 1'b1;
    drive(1'b0, 1'b0, zero, zero);
    rst = 1'b0;
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      chk("flush_vld", bus.valid_out, 1'b0);
      chk("flush_R", bus.dout_R, all0);
      drive(1'b0, 1'b0, zero, zero);
    end
    chk("flush_cnt", n_out - base, 0);
    drive(1'b1, 1'b0, c100, zero);
    repeat (3) drive(1'b0, 1'b0, zero, zero);
    chk("post_rst_R", rec_r[base], all100);
    chk("post_rst_Q", rec_q[base], all0);

    // Random frame with extremes at b=16 and a mid-frame sof at beat 20.
    base = n_out;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        rr[k] = W'($urandom);
        rq[k] = W'($urandom);
      end
      if (i == 16) begin
        rr[2] = 10'h200;
        rq[2] = 10'h200;
        rr[3] = 10'h1FF;
        rq[3] = 10'h200;
      end
      if (i == 20) begin
        rr = c100;
        rq = zero;
      end
      drive(1'b1, i == 0 || i == 20, rr, rq);
    end
    repeat (3) drive(1'b0, 1'b0, zero, zero);
    chk("ext_l2", {rec_r[base+16][2], rec_q[base+16][2]}, pr(-604, -404));
    chk("ext_l3", {rec_r[base+16][3], rec_q[base+16][3]}, pr(403, -604));
    chk("midsof_R", rec_r[base+20], all100);
    chk("midsof_Q", rec_q[base+20], all0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
